// File: rtl/div_ctrl.sv
// div_ctrl: RV32M DIV/DIVU/REM/REMU front end for an unsigned iterative divider core.
// Optional feature: define DIV_RESULT_CACHE_EN for a one-entry cache of the last divider result.
module div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o,
  output logic            div_req_o,
  output logic [XLEN-1:0] div_a_o,
  output logic [XLEN-1:0] div_b_o,
  output logic            div_is_q_o,
  input  logic [XLEN-1:0] div_result_i,
  input  logic            div_ready_i
);

  localparam logic [XLEN-1:0] ZERO_W = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_W = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_W  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIX  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? twos_neg(v) : v;
  endfunction

  state_e          state_r, state_nxt_s;
  logic            is_q_r, neg_q_r, neg_r_r;
  logic [XLEN-1:0] result_r, div_a_r, div_b_r;
  logic            accept_s, signed_s, special_s, hit_s, fix_done_s;
  logic [XLEN-1:0] special_res_s, cache_res_s, fix_res_s;

  // Request classification: RISC-V divide-by-zero and signed-overflow results bypass the divider.
  always_comb begin
    signed_s      = ~op_i[0];
    accept_s      = (state_r == ST_IDLE) & valid_i & ~flush_i;
    special_s     = 1'b0;
    special_res_s = ZERO_W;
    if (b_i == ZERO_W) begin
      special_s     = 1'b1;
      special_res_s = op_i[1] ? a_i : ONES_W;
    end else if (signed_s && (a_i == MIN_W) && (b_i == ONES_W)) begin
      special_s     = 1'b1;
      special_res_s = op_i[1] ? ZERO_W : MIN_W;
    end else begin
      special_s     = 1'b0;
      special_res_s = ZERO_W;
    end
  end

  assign fix_res_s   = (is_q_r ? neg_q_r : neg_r_r) ? twos_neg(result_r) : result_r;
  assign fix_done_s  = (state_r == ST_FIX) & ~flush_i;

`ifdef DIV_RESULT_CACHE_EN
  logic            cache_vld_r;
  logic [1:0]      cache_op_r, req_op_r;
  logic [XLEN-1:0] cache_a_r, cache_b_r, cache_res_r, req_a_r, req_b_r;

  // Last completed divider operation; a flush leaves the entry intact.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cache_vld_r <= 1'b0;
      cache_op_r  <= 2'b00;
      cache_a_r   <= ZERO_W;
      cache_b_r   <= ZERO_W;
      cache_res_r <= ZERO_W;
      req_op_r    <= 2'b00;
      req_a_r     <= ZERO_W;
      req_b_r     <= ZERO_W;
    end else begin
      if (accept_s) begin
        req_op_r <= op_i;
        req_a_r  <= a_i;
        req_b_r  <= b_i;
      end
      if (fix_done_s) begin
        cache_vld_r <= 1'b1;
        cache_op_r  <= req_op_r;
        cache_a_r   <= req_a_r;
        cache_b_r   <= req_b_r;
        cache_res_r <= fix_res_s;
      end
    end
  end

  assign hit_s       = cache_vld_r & (cache_op_r == op_i) & (cache_a_r == a_i) & (cache_b_r == b_i);
  assign cache_res_s = cache_res_r;
`else
  assign hit_s       = 1'b0;
  assign cache_res_s = ZERO_W;
`endif

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; flush wins over everything, including a same-cycle request.
  always_comb begin
    state_nxt_s = state_r;
    if (flush_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (valid_i) begin
            state_nxt_s = (special_s | hit_s) ? ST_OUT : ST_WAIT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (div_ready_i) begin
            state_nxt_s = ST_FIX;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_FIX:  state_nxt_s = ST_OUT;
        ST_OUT: begin
          if (ready_i) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_OUT;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM outputs decoded from the state register only.
  always_comb begin
    ready_o   = 1'b0;
    busy_o    = 1'b1;
    valid_o   = 1'b0;
    div_req_o = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
      end
      ST_WAIT: div_req_o = 1'b1;
      ST_FIX:  busy_o    = 1'b1;
      ST_OUT:  valid_o   = 1'b1;
      default: busy_o    = 1'b1;
    endcase
  end

  // Operand magnitudes, sign flags and the result register that holds through OUT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      is_q_r   <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      result_r <= ZERO_W;
      div_a_r  <= ZERO_W;
      div_b_r  <= ZERO_W;
    end else if (accept_s) begin
      is_q_r  <= ~op_i[1];
      neg_q_r <= signed_s & (a_i[XLEN-1] ^ b_i[XLEN-1]);
      neg_r_r <= signed_s & a_i[XLEN-1];
      if (special_s) begin
        result_r <= special_res_s;
      end else if (hit_s) begin
        result_r <= cache_res_s;
      end else begin
        div_a_r <= magnitude(a_i, signed_s);
        div_b_r <= magnitude(b_i, signed_s);
      end
    end else if ((state_r == ST_WAIT) && div_ready_i && !flush_i) begin
      result_r <= div_result_i;
    end else if (fix_done_s) begin
      result_r <= fix_res_s;
    end
  end

  assign result_o   = result_r;
  assign div_a_o    = div_a_r;
  assign div_b_o    = div_b_r;
  assign div_is_q_o = is_q_r;

endmodule
